// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: source encoding, widths and round-robin helper.
package cdb_arbiter_pkg;

   // ROB index width used as the default CDB index width.
   localparam int unsigned ROB_ENTRY_WIDTH = 5;

   localparam int unsigned NUM_SRC = 3;

   // Source encoding carried on cdb_src.
   localparam logic [1:0] SRC_ALU = 2'd0;
   localparam logic [1:0] SRC_LSQ = 2'd1;
   localparam logic [1:0] SRC_BRA = 2'd2;

   // Width of one plain result entry (ALU / LSQ FIFOs).
   function automatic int unsigned res_entry_w(input int unsigned idx_w,
                                               input int unsigned data_w);
      return idx_w + data_w;
   endfunction

   // Width of one CDB broadcast: src, idx, data, jump_en, jump_addr.
   function automatic int unsigned cdb_entry_w(input int unsigned idx_w,
                                               input int unsigned data_w);
      return 2 + idx_w + data_w + 1 + data_w;
   endfunction

   // Next source in ALU -> LSQ -> BRA -> ALU order.
   function automatic logic [1:0] rr_next(input logic [1:0] src);
      return (src == SRC_BRA) ? SRC_ALU : src + 2'd1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// Small per-source result FIFO with synchronous flush; flush wins over push.
module result_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push, do_pop;

   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr_q];

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry storage; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (do_push && !flush && !rst) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin writeback arbiter driving a registered, single-broadcast CDB.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IDX_W  = ROB_ENTRY_WIDTH,
   parameter int unsigned DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rollback,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [IDX_W-1:0]  alu_idx,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              lsq_valid,
   output logic              lsq_ready,
   input  logic [IDX_W-1:0]  lsq_idx,
   input  logic [DATA_W-1:0] lsq_data,
   input  logic              bra_valid,
   output logic              bra_ready,
   input  logic [IDX_W-1:0]  bra_idx,
   input  logic [DATA_W-1:0] bra_data,
   input  logic              bra_jump_en,
   input  logic [DATA_W-1:0] bra_jump_addr,
   output logic              cdb_valid,
   output logic [1:0]        cdb_src,
   output logic [IDX_W-1:0]  cdb_idx,
   output logic [DATA_W-1:0] cdb_data,
   output logic              cdb_jump_en,
   output logic [DATA_W-1:0] cdb_jump_addr
);

   localparam int unsigned RES_W = res_entry_w(IDX_W, DATA_W);
   localparam int unsigned BRA_W = RES_W + DATA_W + 1;

   logic             alu_full, alu_empty, lsq_full, lsq_empty, bra_full, bra_empty;
   logic [RES_W-1:0] alu_head, lsq_head;
   logic [BRA_W-1:0] bra_head;
   logic [3:0]       non_empty;
   logic [2:0]       pop;
   logic [1:0]       rr_q, rr_d, cand, gnt_src;
   logic             gnt_valid;

   logic [IDX_W-1:0]  nxt_idx;
   logic [DATA_W-1:0] nxt_data, nxt_jump_addr;
   logic              nxt_jump_en;

   // Ready looks only at registered occupancy, never at a same-cycle pop.
   assign alu_ready = ~alu_full;
   assign lsq_ready = ~lsq_full;
   assign bra_ready = ~bra_full;

   // Bit 3 pads the vector so every 2-bit candidate index is in range.
   assign non_empty = {1'b0, ~bra_empty, ~lsq_empty, ~alu_empty};

   result_fifo #(.DEPTH(DEPTH), .WIDTH(RES_W)) u_alu_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (rollback),
      .push  (alu_valid & alu_ready),
      .din   ({alu_idx, alu_data}),
      .pop   (pop[0]),
      .dout  (alu_head),
      .full  (alu_full),
      .empty (alu_empty)
   );

   result_fifo #(.DEPTH(DEPTH), .WIDTH(RES_W)) u_lsq_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (rollback),
      .push  (lsq_valid & lsq_ready),
      .din   ({lsq_idx, lsq_data}),
      .pop   (pop[1]),
      .dout  (lsq_head),
      .full  (lsq_full),
      .empty (lsq_empty)
   );

   result_fifo #(.DEPTH(DEPTH), .WIDTH(BRA_W)) u_bra_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (rollback),
      .push  (bra_valid & bra_ready),
      .din   ({bra_jump_en, bra_jump_addr, bra_idx, bra_data}),
      .pop   (pop[2]),
      .dout  (bra_head),
      .full  (bra_full),
      .empty (bra_empty)
   );

   // Round-robin search from rr_q; a rollback suppresses the grant so nothing is popped.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_src   = rr_q;
      cand      = rr_q;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (!gnt_valid && non_empty[cand]) begin
            gnt_valid = 1'b1;
            gnt_src   = cand;
         end
         cand = rr_next(cand);
      end
      if (rollback) gnt_valid = 1'b0;
      rr_d = gnt_valid ? rr_next(gnt_src) : rr_q;
      pop  = '0;
      if (gnt_valid) begin
         case (gnt_src)
            SRC_ALU: pop[0] = 1'b1;
            SRC_LSQ: pop[1] = 1'b1;
            SRC_BRA: pop[2] = 1'b1;
            default: pop    = '0;
         endcase
      end
   end

   // Head select; jump fields exist only in the BRA entry and are zero otherwise.
   always_comb begin
      nxt_jump_en   = 1'b0;
      nxt_jump_addr = '0;
      case (gnt_src)
         SRC_LSQ: {nxt_idx, nxt_data} = lsq_head;
         SRC_BRA: {nxt_jump_en, nxt_jump_addr, nxt_idx, nxt_data} = bra_head;
         default: {nxt_idx, nxt_data} = alu_head;
      endcase
   end

   // CDB output register and round-robin pointer; fields hold when nothing is granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q          <= SRC_ALU;
         cdb_valid     <= 1'b0;
         cdb_src       <= '0;
         cdb_idx       <= '0;
         cdb_data      <= '0;
         cdb_jump_en   <= 1'b0;
         cdb_jump_addr <= '0;
      end else begin
         rr_q      <= rr_d;
         cdb_valid <= gnt_valid;
         if (gnt_valid) begin
            cdb_src       <= gnt_src;
            cdb_idx       <= nxt_idx;
            cdb_data      <= nxt_data;
            cdb_jump_en   <= nxt_jump_en;
            cdb_jump_addr <= nxt_jump_addr;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized scoreboard bench for cdb_arbiter with a queue-level reference model.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned IDX_W  = ROB_ENTRY_WIDTH;
   localparam int unsigned DEPTH  = 2;

   typedef struct packed {
      logic [1:0]        src;
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
      logic              jen;
      logic [DATA_W-1:0] jaddr;
   } bc_t;

   logic              clk = 1'b0;
   logic              rst, rollback;
   logic              alu_valid, alu_ready, lsq_valid, lsq_ready, bra_valid, bra_ready;
   logic [IDX_W-1:0]  alu_idx, lsq_idx, bra_idx, cdb_idx;
   logic [DATA_W-1:0] alu_data, lsq_data, bra_data, bra_jump_addr, cdb_data, cdb_jump_addr;
   logic              bra_jump_en, cdb_valid, cdb_jump_en;
   logic [1:0]        cdb_src;

   cdb_arbiter #(.DATA_W(DATA_W), .IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .rollback      (rollback),
      .alu_valid     (alu_valid),
      .alu_ready     (alu_ready),
      .alu_idx       (alu_idx),
      .alu_data      (alu_data),
      .lsq_valid     (lsq_valid),
      .lsq_ready     (lsq_ready),
      .lsq_idx       (lsq_idx),
      .lsq_data      (lsq_data),
      .bra_valid     (bra_valid),
      .bra_ready     (bra_ready),
      .bra_idx       (bra_idx),
      .bra_data      (bra_data),
      .bra_jump_en   (bra_jump_en),
      .bra_jump_addr (bra_jump_addr),
      .cdb_valid     (cdb_valid),
      .cdb_src       (cdb_src),
      .cdb_idx       (cdb_idx),
      .cdb_data      (cdb_data),
      .cdb_jump_en   (cdb_jump_en),
      .cdb_jump_addr (cdb_jump_addr)
   );

   always #5 clk = ~clk;

   // Reference state: one queue per source, expected broadcasts, last broadcast.
   bc_t q_alu[$], q_lsq[$], q_bra[$], exp_q[$];
   bc_t m_last;
   int  m_rr;
   int  n_vec = 0;
   int  n_bad = 0;

   function automatic bc_t mk(input logic [1:0] s, input logic [IDX_W-1:0] i,
                              input logic [DATA_W-1:0] d, input logic j,
                              input logic [DATA_W-1:0] a);
      bc_t e;
      e.src = s; e.idx = i; e.data = d; e.jen = j; e.jaddr = a;
      return e;
   endfunction

   function automatic int qsize(input int s);
      if (s == 0) return q_alu.size();
      if (s == 1) return q_lsq.size();
      return q_bra.size();
   endfunction

   function automatic bc_t qpop(input int s);
      if (s == 0) return q_alu.pop_front();
      if (s == 1) return q_lsq.pop_front();
      return q_bra.pop_front();
   endfunction

   // One clock of the abstract model: grant from pre-edge contents, then accept pushes.
   task automatic model_step();
      bit ra, rl, rb, g;
      int s;
      bc_t e;
      if (rst) begin
         q_alu.delete(); q_lsq.delete(); q_bra.delete(); exp_q.delete();
         m_rr   = 0;
         m_last = '0;
      end else if (rollback) begin
         q_alu.delete(); q_lsq.delete(); q_bra.delete();
      end else begin
         ra = q_alu.size() < DEPTH;
         rl = q_lsq.size() < DEPTH;
         rb = q_bra.size() < DEPTH;
         g  = 1'b0;
         for (int k = 0; k < 3; k++) begin
            s = (m_rr + k) % 3;
            if (!g && qsize(s) > 0) begin
               e = qpop(s);
               exp_q.push_back(e);
               m_last = e;
               m_rr   = (s + 1) % 3;
               g      = 1'b1;
            end
         end
         if (alu_valid && ra) q_alu.push_back(mk(2'd0, alu_idx, alu_data, 1'b0, '0));
         if (lsq_valid && rl) q_lsq.push_back(mk(2'd1, lsq_idx, lsq_data, 1'b0, '0));
         if (bra_valid && rb) q_bra.push_back(mk(2'd2, bra_idx, bra_data, bra_jump_en,
                                                 bra_jump_addr));
      end
   endtask

   // Monitor: pops an expected broadcast whenever the CDB is valid, checks hold otherwise.
   task automatic monitor_step();
      bc_t got, e;
      logic [2:0] exp_rdy;
      got = {cdb_src, cdb_idx, cdb_data, cdb_jump_en, cdb_jump_addr};
      n_vec++;
      if (cdb_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL spurious_bcast t=%0t got=%h required=none", $time, got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               n_bad++;
               $display("FAIL bcast t=%0t got=%h required=%h", $time, got, e);
            end
         end
      end else if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n_bad++;
         $display("FAIL missing_bcast t=%0t cdb_valid=%b required=%h", $time, cdb_valid, e);
      end else if (cdb_valid !== 1'b0 || got !== m_last) begin
         n_bad++;
         $display("FAIL idle_hold t=%0t valid=%b got=%h required=%h", $time, cdb_valid,
                  got, m_last);
      end
      n_vec++;
      exp_rdy = {q_bra.size() < DEPTH, q_lsq.size() < DEPTH, q_alu.size() < DEPTH};
      if ({bra_ready, lsq_ready, alu_ready} !== exp_rdy) begin
         n_bad++;
         $display("FAIL ready t=%0t got=%b required=%b", $time,
                  {bra_ready, lsq_ready, alu_ready}, exp_rdy);
      end
   endtask

   always @(posedge clk) model_step();
   always @(negedge clk) monitor_step();

   task automatic clear_inputs();
      rollback = 1'b0;
      alu_valid = 1'b0; alu_idx = '0; alu_data = '0;
      lsq_valid = 1'b0; lsq_idx = '0; lsq_data = '0;
      bra_valid = 1'b0; bra_idx = '0; bra_data = '0;
      bra_jump_en = 1'b0; bra_jump_addr = '0;
   endtask

   task automatic idle(input int n);
      clear_inputs();
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(5);

      // Single ALU push.
      alu_valid = 1'b1; alu_idx = 3; alu_data = 32'h11;
      @(negedge clk);
      idle(3);

      // All three sources in one cycle.
      alu_valid = 1'b1; alu_idx = 1; alu_data = 32'hA;
      lsq_valid = 1'b1; lsq_idx = 2; lsq_data = 32'hB;
      bra_valid = 1'b1; bra_idx = 4; bra_data = 32'hC;
      bra_jump_en = 1'b1; bra_jump_addr = 32'h40;
      @(negedge clk);
      idle(5);

      // Backpressure: ALU and LSQ both offering every cycle.
      for (int i = 0; i < 20; i++) begin
         alu_valid = 1'b1; alu_idx = IDX_W'(i); alu_data = $urandom;
         lsq_valid = 1'b1; lsq_idx = IDX_W'(i + 16); lsq_data = $urandom;
         @(negedge clk);
      end
      idle(6);

      // Fill every FIFO, then rollback with a same-cycle push from each source.
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1'b1; alu_idx = IDX_W'(i); alu_data = $urandom;
         lsq_valid = 1'b1; lsq_idx = IDX_W'(i + 8); lsq_data = $urandom;
         bra_valid = 1'b1; bra_idx = IDX_W'(i + 16); bra_data = $urandom;
         bra_jump_en = 1'b1; bra_jump_addr = $urandom;
         @(negedge clk);
      end
      rollback = 1'b1;
      alu_idx = 5'd30; lsq_idx = 5'd29; bra_idx = 5'd28;
      @(negedge clk);
      idle(4);

      // Seven back-to-back BRA pushes across pointer wrap.
      for (int i = 0; i < 7; i++) begin
         bra_valid = 1'b1; bra_idx = IDX_W'(i + 1); bra_data = $urandom;
         bra_jump_en = 1'($urandom); bra_jump_addr = $urandom;
         @(negedge clk);
      end
      idle(4);

      // Random traffic with occasional rollback and reset.
      for (int i = 0; i < 500; i++) begin
         alu_valid = ($urandom_range(0, 9) < 6); alu_idx = IDX_W'($urandom);
         alu_data = $urandom;
         lsq_valid = ($urandom_range(0, 9) < 6); lsq_idx = IDX_W'($urandom);
         lsq_data = $urandom;
         bra_valid = ($urandom_range(0, 9) < 5); bra_idx = IDX_W'($urandom);
         bra_data = $urandom;
         bra_jump_en = 1'($urandom); bra_jump_addr = $urandom;
         rollback = ($urandom_range(0, 39) == 0);
         rst = ($urandom_range(0, 149) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
